// File: rtl/pc_pkg.sv
// Shared types and constants for the PC redirect control path: FSM states,
// request kinds and the {PCorBranch, Jump, jr} select encodings of the PC mux.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PEND    = 2'd1,
    ST_JR_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_BR   = 2'd1,
    REQ_J    = 2'd2,
    REQ_JR   = 2'd3
  } req_e;

  localparam logic [2:0] SEL_PC4 = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b100;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b001;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [2:0] req_sel(input req_e kind);
    case (kind)
      REQ_BR:  return SEL_BR;
      REQ_J:   return SEL_J;
      REQ_JR:  return SEL_JR;
      default: return SEL_PC4;
    endcase
  endfunction

endpackage

// File: rtl/redirect_counter.sv
// Saturating up-counter of taken redirects; sticks at all-ones.
module redirect_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register plus redirect control: resolves ID branch/jump/jr requests into
// one-hot PC mux selects, and flushes IF/ID or holds ID until the redirect lands.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = pc_pkg::DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_next,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             br_taken,
  input  logic             jump_req,
  input  logic             jr_req,
  input  logic             jr_rs_hazard,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             PCorBranch,
  output logic             Jump,
  output logic             jr,
  output logic             flush_ifid,
  output logic             hold_id,
  output logic             multi_req_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  import pc_pkg::*;

  state_e      state_q, state_d;
  req_e        kind_q, kind_d;
  req_e        win, fire_kind;
  logic [31:0] pc_q, pc_d;
  logic        err_q;
  logic        advance, fire, hold, pc_ld, multi;
  logic [1:0]  nreq;

  assign advance = imem_ready & ~stall;
  assign nreq    = {1'b0, br_taken} + {1'b0, jump_req} + {1'b0, jr_req};
  assign multi   = (nreq > 2'd1);

  always_comb begin
    if (jr_req)        win = REQ_JR;
    else if (jump_req) win = REQ_J;
    else if (br_taken) win = REQ_BR;
    else               win = REQ_NONE;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    fire      = 1'b0;
    fire_kind = REQ_NONE;
    hold      = 1'b0;
    pc_ld     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if ((win == REQ_JR) && jr_rs_hazard) begin
          hold    = 1'b1;
          state_d = ST_JR_WAIT;
          kind_d  = REQ_JR;
        end else if (win != REQ_NONE) begin
          if (advance) begin
            fire      = 1'b1;
            fire_kind = win;
          end else begin
            hold    = 1'b1;
            state_d = ST_PEND;
            kind_d  = win;
          end
        end else begin
          pc_ld = advance;
        end
      end
      ST_PEND: begin
        // ID is frozen here, so live request inputs are deliberately ignored.
        if (advance) begin
          fire      = 1'b1;
          fire_kind = kind_q;
          state_d   = ST_RUN;
          kind_d    = REQ_NONE;
        end else begin
          hold = 1'b1;
        end
      end
      ST_JR_WAIT: begin
        if (advance && !jr_rs_hazard) begin
          fire      = 1'b1;
          fire_kind = REQ_JR;
          state_d   = ST_RUN;
          kind_d    = REQ_NONE;
        end else begin
          hold = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        kind_d  = REQ_NONE;
      end
    endcase
  end

  assign pc_d = (pc_ld || fire) ? pc_next : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      kind_q  <= REQ_NONE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      if (multi) err_q <= 1'b1;
    end
  end

  redirect_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (fire),
    .cnt_o (redirect_cnt)
  );

  // Handshake outputs are forced low while reset is asserted, even with live requests.
  assign {PCorBranch, Jump, jr} = (fire && rst_n) ? req_sel(fire_kind) : SEL_PC4;
  assign flush_ifid    = fire & rst_n;
  assign hold_id       = hold & rst_n;
  assign multi_req_err = err_q;
  assign pc            = pc_q;
  assign pc4           = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: a request-level model checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_pc_redirect_ctrl;

  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc_next = '0;
  logic          stall = 1'b0, imem_ready = 1'b0;
  logic          br_taken = 1'b0, jump_req = 1'b0, jr_req = 1'b0, jr_rs_hazard = 1'b0;
  logic [31:0]   pc, pc4;
  logic          PCorBranch, Jump, jr, flush_ifid, hold_id, multi_req_err;
  logic [CW-1:0] redirect_cnt;

  pc_redirect_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk (clk), .rst_n (rst_n), .pc_next (pc_next), .stall (stall),
    .imem_ready (imem_ready), .br_taken (br_taken), .jump_req (jump_req),
    .jr_req (jr_req), .jr_rs_hazard (jr_rs_hazard), .pc (pc), .pc4 (pc4),
    .PCorBranch (PCorBranch), .Jump (Jump), .jr (jr), .flush_ifid (flush_ifid),
    .hold_id (hold_id), .multi_req_err (multi_req_err), .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: waiting = 0 idle, 1 redirect owed on next advance, 2 jr waiting on RS.
  logic [31:0] m_pc;
  int          m_cnt, m_wait, m_kind;
  logic        m_err;
  logic [2:0]  e_sel;
  logic        e_flush, e_hold, e_load, e_multi;
  int          n_wait, n_kind;

  function automatic logic [2:0] sel_of(input int kind);
    case (kind)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always @* begin
    logic adv;
    int   win, fk;
    logic fire;
    adv     = imem_ready & ~stall;
    e_multi = (int'(br_taken) + int'(jump_req) + int'(jr_req)) > 1;
    win     = jr_req ? 3 : jump_req ? 2 : br_taken ? 1 : 0;
    fire = 1'b0; fk = 0; e_hold = 1'b0; e_load = 1'b0;
    n_wait = m_wait; n_kind = m_kind;
    if (m_wait == 0) begin
      if (win == 3 && jr_rs_hazard) begin e_hold = 1'b1; n_wait = 2; end
      else if (win != 0 && adv)     begin fire = 1'b1; fk = win; end
      else if (win != 0)            begin e_hold = 1'b1; n_wait = 1; n_kind = win; end
      else                          e_load = adv;
    end else if (m_wait == 1) begin
      if (adv) begin fire = 1'b1; fk = m_kind; n_wait = 0; end
      else e_hold = 1'b1;
    end else begin
      if (adv && !jr_rs_hazard) begin fire = 1'b1; fk = 3; n_wait = 0; end
      else e_hold = 1'b1;
    end
    e_flush = fire;
    e_load  = e_load | fire;
    e_sel   = sel_of(fk);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_cnt <= 0; m_err <= 1'b0; m_wait <= 0; m_kind <= 0;
    end else begin
      if (e_load) m_pc <= pc_next;
      if (e_flush && m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
      if (e_multi) m_err <= 1'b1;
      m_wait <= n_wait;
      m_kind <= n_kind;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("pc",            pc,                                m_pc);
      check("pc4",           pc4,                               m_pc + 32'd4);
      check("selects",       32'({PCorBranch, Jump, jr}),       32'(e_sel));
      check("flush_ifid",    32'(flush_ifid),                   32'(e_flush));
      check("hold_id",       32'(hold_id),                      32'(e_hold));
      check("multi_req_err", 32'(multi_req_err),                32'(m_err));
      check("redirect_cnt",  32'(redirect_cnt),                 32'(m_cnt));
    end
  end

  task automatic apply(input logic st, rdy, br, j, jrr, hz, input logic [31:0] nxt);
    stall = st; imem_ready = rdy; br_taken = br; jump_req = j;
    jr_req = jrr; jr_rs_hazard = hz; pc_next = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, rdy, br, j, jrr, hz, input logic [31:0] nxt);
    apply(st, rdy, br, j, jrr, hz, nxt);
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",  pc, RPC);
    check("reset_sel", 32'({PCorBranch, Jump, jr, flush_ifid, hold_id}), 32'd0);
    check("reset_cnt", 32'(redirect_cnt), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Straight-line fetch.
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, m_pc + 32'd4);
    check("seq_pc", pc, 32'd12);

    // Taken branch with advance.
    apply(0, 1, 1, 0, 0, 0, 32'h40);
    #2;
    check("br_sel",   32'({PCorBranch, Jump, jr, flush_ifid}), 32'b1001);
    step();
    check("br_pc",  pc, 32'h40);
    check("br_cnt", 32'(redirect_cnt), 32'd1);
    drive(0, 1, 0, 0, 0, 0, m_pc + 32'd4);

    // Jump while imem not ready for two cycles.
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 1, 0, 0, 32'h200);
      #2;
      check("j_hold", 32'({PCorBranch, Jump, jr, hold_id}), 32'b0001);
      step();
    end
    apply(0, 1, 0, 1, 0, 0, 32'h200);
    #2;
    check("j_fire", 32'({PCorBranch, Jump, jr, flush_ifid, hold_id}), 32'b01010);
    step();
    check("j_pc", pc, 32'h200);
    drive(0, 1, 0, 0, 0, 0, m_pc + 32'd4);

    // jr blocked by RS hazard for three cycles.
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 1, 32'h3000);
    check("jr_frozen_pc", pc, 32'h204);
    apply(0, 1, 0, 0, 1, 0, 32'h3000);
    #2;
    check("jr_fire", 32'({PCorBranch, Jump, jr, flush_ifid}), 32'b0011);
    step();
    check("jr_pc", pc, 32'h3000);

    // jr and branch together: jr wins, error is sticky.
    drive(0, 1, 1, 0, 1, 0, 32'h50);
    check("multi_err", 32'(multi_req_err), 32'd1);
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0, 0, m_pc + 32'd4);
    check("multi_sticky", 32'(multi_req_err), 32'd1);

    // pc4 wraparound at the top of the address space.
    drive(0, 1, 1, 0, 0, 0, 32'hFFFF_FFFC);
    apply(0, 1, 0, 0, 0, 0, m_pc + 32'd4);
    #1;
    check("pc4_wrap", pc4, 32'd0);
    step();
    check("pc_wrap", pc, 32'd0);

    // Stalled fetch with no request holds pc.
    drive(1, 1, 0, 0, 0, 0, 32'h9999);
    drive(0, 0, 0, 0, 0, 0, 32'h9999);
    check("stall_pc", pc, 32'd0);

    // Counter saturation.
    check("cnt_pre_sat", 32'(redirect_cnt), 32'd5);
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 0, 0, 0, m_pc + 32'd8);
    check("cnt_sat", 32'(redirect_cnt), 32'd15);

    // Reset asserted mid-PEND with an advance that would otherwise fire.
    drive(0, 0, 0, 1, 0, 0, 32'h500);
    apply(0, 1, 0, 1, 0, 0, 32'h500);
    #1;
    check("pend_would_fire", 32'(Jump), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_pc",   pc, RPC);
    check("rst_outs", 32'({PCorBranch, Jump, jr, flush_ifid, hold_id, multi_req_err}), 32'd0);
    check("rst_cnt",  32'(redirect_cnt), 32'd0);
    apply(0, 1, 0, 0, 0, 0, 32'h4);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0, 0, m_pc + 32'd4);
    check("post_rst_pc",  pc, 32'd8);
    check("post_rst_cnt", 32'(redirect_cnt), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
